// File: rtl/cpu_flags_pkg.sv
// Shared flag-register definitions: widths, flag bit positions and jump condition codes.
package cpu_flags_pkg;

    localparam int unsigned FLAGS_W = 5;
    localparam int unsigned BUS_W   = 8;
    localparam int unsigned COND_W  = 4;

    // Flag bit positions inside the {CarryL, CarryA, Zero, Sign, Overflow} vector
    localparam int unsigned FLAG_O  = 0;
    localparam int unsigned FLAG_S  = 1;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_CA = 3;
    localparam int unsigned FLAG_CL = 4;

    localparam logic [FLAGS_W-1:0] RESET_FLAGS = 5'b00000;

    typedef enum logic [COND_W-1:0] {
        COND_ALWAYS = 4'd0,
        COND_NEVER  = 4'd1,
        COND_Z      = 4'd2,
        COND_NZ     = 4'd3,
        COND_CA     = 4'd4,
        COND_NCA    = 4'd5,
        COND_S      = 4'd6,
        COND_NS     = 4'd7,
        COND_O      = 4'd8,
        COND_NO     = 4'd9,
        COND_CL     = 4'd10,
        COND_NCL    = 4'd11,
        COND_UGT    = 4'd12,
        COND_ULE    = 4'd13,
        COND_SLT    = 4'd14,
        COND_SGE    = 4'd15
    } cond_code_e;

endpackage

// File: rtl/flags_cond_eval.sv
// Combinational jump-condition evaluator: tests one condition code against a flags vector.
module flags_cond_eval
    import cpu_flags_pkg::*;
(
    input  logic [COND_W-1:0]  cond_code,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_true_c
);

    logic f_o;
    logic f_s;
    logic f_z;
    logic f_ca;
    logic f_cl;

    assign f_o  = flags[FLAG_O];
    assign f_s  = flags[FLAG_S];
    assign f_z  = flags[FLAG_Z];
    assign f_ca = flags[FLAG_CA];
    assign f_cl = flags[FLAG_CL];

    // Select the predicate named by the condition code
    always_comb begin
        cond_true_c = 1'b0;
        case (cond_code_e'(cond_code))
            COND_ALWAYS: cond_true_c = 1'b1;
            COND_NEVER:  cond_true_c = 1'b0;
            COND_Z:      cond_true_c = f_z;
            COND_NZ:     cond_true_c = !f_z;
            COND_CA:     cond_true_c = f_ca;
            COND_NCA:    cond_true_c = !f_ca;
            COND_S:      cond_true_c = f_s;
            COND_NS:     cond_true_c = !f_s;
            COND_O:      cond_true_c = f_o;
            COND_NO:     cond_true_c = !f_o;
            COND_CL:     cond_true_c = f_cl;
            COND_NCL:    cond_true_c = !f_cl;
            COND_UGT:    cond_true_c = f_ca & !f_z;
            COND_ULE:    cond_true_c = !f_ca | f_z;
            COND_SLT:    cond_true_c = f_s ^ f_o;
            COND_SGE:    cond_true_c = !(f_s ^ f_o);
            default:     cond_true_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_unit.sv
// Flags register, branch-condition evaluator and MainBus flag push/pop port.
// Optional interrupt shadow copy of the flags, enabled by defining FLAGS_SHADOW_EN.
module alu_flags_unit
    import cpu_flags_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    inout  wire  [BUS_W-1:0]   MainBus,
    input  logic [FLAGS_W-1:0] AluFlags,
    input  logic               AluFlagWrite,
    input  logic               FlagsAssert_n,
    input  logic               FlagsLoad_n,
    input  logic               CondValid,
    input  logic [COND_W-1:0]  CondCode,
    input  logic               IrqEnter,
    input  logic               IrqReturn,
    output logic [FLAGS_W-1:0] Flags,
    output logic               LCarryIn,
    output logic               CondTrue,
    output logic               CondDone
);

    logic [FLAGS_W-1:0] flags_q;
    logic [FLAGS_W-1:0] flags_next;
    logic               cond_eval_c;
    logic               cond_true_q;
    logic               cond_done_q;
    logic               bus_drive_c;

`ifdef FLAGS_SHADOW_EN
    logic [FLAGS_W-1:0] shadow_q;
`else
    logic               unused_irq;
    assign unused_irq = IrqEnter ^ IrqReturn;
`endif

    // Upper bus bits carry no flag information on load
    logic unused_bus_hi;
    assign unused_bus_hi = ^MainBus[BUS_W-1:FLAGS_W];

    // Next flags value: bus load beats shadow restore beats ALU write beats hold
    always_comb begin
        flags_next = flags_q;
        if (!FlagsLoad_n) begin
            flags_next = MainBus[FLAGS_W-1:0];
        end
`ifdef FLAGS_SHADOW_EN
        else if (IrqReturn) begin
            flags_next = shadow_q;
        end
`endif
        else if (AluFlagWrite) begin
            flags_next = AluFlags;
        end
    end

    // Flags register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_next;
        end
    end

`ifdef FLAGS_SHADOW_EN
    // Interrupt shadow saves the pre-update flags value
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shadow_q <= RESET_FLAGS;
        end else if (IrqEnter) begin
            shadow_q <= flags_q;
        end
    end
`endif

    // Conditions see the flags being written this edge so a dependent jump needs no bubble
    flags_cond_eval u_cond_eval (
        .cond_code   (CondCode),
        .flags       (flags_next),
        .cond_true_c (cond_eval_c)
    );

    // Condition result holds between evaluations; done pulses once per accepted evaluation
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cond_true_q <= 1'b0;
            cond_done_q <= 1'b0;
        end else begin
            cond_done_q <= CondValid;
            if (CondValid) begin
                cond_true_q <= cond_eval_c;
            end
        end
    end

    // Drive is withheld when a load is requested at the same time, leaving the bus to the loader
    assign bus_drive_c = !FlagsAssert_n && FlagsLoad_n;
    assign MainBus     = bus_drive_c ? {(BUS_W-FLAGS_W)'(0), flags_q} : {BUS_W{1'bz}};

    assign Flags    = flags_q;
    assign LCarryIn = flags_q[FLAG_CL];
    assign CondTrue = cond_true_q;
    assign CondDone = cond_done_q;

endmodule
